// File: rtl/router_pkg.sv
// Shared types and constants for the router output-port allocator.
package router_pkg;

  localparam int unsigned NUM_PORTS      = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned TAIL_BIT       = DATA_WIDTH_DEF - 1;
  localparam int unsigned PORT_IDX_W     = $clog2(NUM_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Modular add for indices already below n, with off < n; avoids a divider.
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int unsigned N     = NUM_PORTS,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_valid
);

  int unsigned w_idx;

  // Cyclic scan starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = wrap_add(32'(i_ptr), k, N);
      if (!o_valid && i_req[IDX_W'(w_idx)]) begin
        o_valid = 1'b1;
        o_grant = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole allocator for one output port: round-robin grant, packet lock
// until the tail flit transfers, FIFO-to-FIFO flit move gated by out_full.
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = NUM_PORTS,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_empty,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]            in_pop,
  input  logic                             out_full,
  output logic                             out_push,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             busy,
  output logic [$clog2(NUM_INPUTS)-1:0]    owner
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       w_owner_nxt;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       w_rr_ptr_nxt;

  logic [NUM_INPUTS-1:0]  w_req;
  logic [DATA_WIDTH-1:0]  w_in_word [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_owner_req;
  logic                   w_tail;
  logic                   w_xfer;
  logic [IDX_W-1:0]       w_grant;
  logic                   w_grant_valid;
  logic [NUM_INPUTS-1:0]  w_pop;
  logic                   w_push;

  assign w_req = ~in_empty;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
    assign w_in_word[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  // Owner data mux and transfer qualifier; reset forces the handshake low.
  always_comb begin
    w_sel_data  = w_in_word[r_owner];
    w_owner_req = w_req[r_owner];
    w_tail      = w_sel_data[DATA_WIDTH-1];
    w_xfer      = (r_state == LOCKED) && w_owner_req && !out_full && !reset;
  end

  // Next-state, grant capture, pointer advance and pop/push generation.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_pop        = '0;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_grant;
        end
      end
      LOCKED: begin
        if (w_xfer) begin
          w_pop[r_owner] = 1'b1;
          w_push         = 1'b1;
          if (w_tail) begin
            w_state_nxt  = IDLE;
            w_owner_nxt  = '0;
            w_rr_ptr_nxt = IDX_W'(wrap_add(32'(r_owner), 1, NUM_INPUTS));
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_owner_nxt = '0;
      end
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign in_pop   = w_pop;
  assign out_push = w_push;
  assign out_data = w_sel_data;
  assign busy     = (r_state == LOCKED);
  assign owner    = r_owner;

  a_pop_onehot0 : assert property (@(posedge clk) $onehot0(in_pop));
  a_push_eq_pop : assert property (@(posedge clk) out_push == (|in_pop));
  a_no_push_full: assert property (@(posedge clk) !(out_push && out_full));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: FIFO models per input, expected-flit queue.
module tb_output_port_arbiter;
  import router_pkg::*;

  localparam int N  = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      in_empty;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_pop;
  logic              out_full;
  logic              out_push;
  logic [DW-1:0]     out_data;
  logic              busy;
  logic [2:0]        owner;

  output_port_arbiter #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_empty (in_empty),
    .in_data  (in_data),
    .in_pop   (in_pop),
    .out_full (out_full),
    .out_push (out_push),
    .out_data (out_data),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          src;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo[N][$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          push_hist[8192];
  bit          busy_hist[8192];
  logic [31:0] tail_m;

  function automatic void drive_inputs();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (fifo[i].size() == 0);
      in_data[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : (32'hDEAD_0000 | 32'(i));
    end
  endfunction

  function automatic void load(input int i, input logic [31:0] d);
    fifo[i].push_back(d);
  endfunction

  function automatic void expect_flit(input logic [31:0] d, input int src);
    exp_t e;
    e.data = d;
    e.src  = src;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare each push against the expected queue, model FIFO pops.
  initial begin : monitor
    logic [N-1:0] pops;
    logic [N-1:0] want;
    exp_t         e;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc < 8192) begin
        push_hist[cyc] = out_push;
        busy_hist[cyc] = busy;
      end
      pops = in_pop;
      if (out_push === 1'b1) begin
        n_checks++;
        if (out_full !== 1'b0) begin
          n_fail++;
          $display("FAIL push_while_full: cyc=%0d out_full=%b required no push", cyc, out_full);
        end
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_push: cyc=%0d data=%h required no push", cyc, out_data);
        end else begin
          e = exp_q.pop_front();
          want = '0;
          want[e.src] = 1'b1;
          if (out_data !== e.data || in_pop !== want) begin
            n_fail++;
            $display("FAIL push_data: cyc=%0d data=%h pop=%b required data=%h pop=%b",
                     cyc, out_data, in_pop, e.data, want);
          end
        end
      end else if (in_pop !== '0) begin
        n_fail++;
        $display("FAIL pop_without_push: cyc=%0d pop=%b required 0", cyc, in_pop);
      end
      for (int i = 0; i < N; i++) begin
        if (pops[i] === 1'b1 && in_empty[i] === 1'b1) begin
          n_fail++;
          $display("FAIL pop_empty: cyc=%0d input=%0d popped while empty", cyc, i);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (pops[i] === 1'b1 && fifo[i].size() != 0) void'(fifo[i].pop_front());
      drive_inputs();
    end
  end

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      sample();
      if (exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_%s: pending=%0d busy=%b required pending=0 busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
      for (int i = 0; i < N; i++) fifo[i].delete();
      drive_inputs();
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int c0;
    reset = 1'b1;
    out_full = 1'b0;
    tick();
    tick();
    sample();
    n_checks++;
    if (busy !== 1'b0 || owner !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b owner=%0d required busy=0 owner=0", busy, owner);
    end
    n_checks++;
    if (in_pop !== '0 || out_push !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: pop=%b push=%b required 0 0", in_pop, out_push);
    end
    tick();
    reset = 1'b0;
    repeat (10) begin
      sample();
      n_checks++;
      if (busy !== 1'b0 || out_push !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: busy=%b push=%b required 0 0", busy, out_push);
      end
    end
    tick();
    load(2, 32'h0000_00A1);
    load(2, 32'h0000_00A2);
    load(2, tail_m | 32'h0000_00A3);
    expect_flit(32'h0000_00A1, 2);
    expect_flit(32'h0000_00A2, 2);
    expect_flit(tail_m | 32'h0000_00A3, 2);
    drive_inputs();
    c0 = cyc;
    tick();
    tick();
    reset = 1'b1;
    sample();
    n_checks++;
    if (in_pop !== '0 || out_push !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb_gate: pop=%b push=%b required 0 0", in_pop, out_push);
    end
    sample();
    n_checks++;
    if (busy !== 1'b0 || in_pop !== '0 || owner !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_midpacket: busy=%b pop=%b owner=%0d required 0 0 0", busy, in_pop, owner);
    end
    n_checks++;
    if (push_hist[c0+2] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_push: push=%b required 1", push_hist[c0+2]);
    end
    tick();
    reset = 1'b0;
    wait_drain(30, "reset_resume");
  endtask

  task automatic test_single_packet();
    int        c0;
    port_idx_t exp_ptr;
    load(2, 32'h0000_0001);
    load(2, 32'h0000_0002);
    load(2, 32'h8000_0003);
    expect_flit(32'h0000_0001, 2);
    expect_flit(32'h0000_0002, 2);
    expect_flit(32'h8000_0003, 2);
    drive_inputs();
    c0 = cyc;
    wait_drain(30, "single");
    n_checks++;
    if (push_hist[c0+1] !== 1'b0 || push_hist[c0+2] !== 1'b1 ||
        push_hist[c0+3] !== 1'b1 || push_hist[c0+4] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_timing: pushes=%b%b%b%b required 0111",
               push_hist[c0+1], push_hist[c0+2], push_hist[c0+3], push_hist[c0+4]);
    end
    n_checks++;
    if (busy_hist[c0+4] !== 1'b1 || busy_hist[c0+5] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: busy=%b%b required 10", busy_hist[c0+4], busy_hist[c0+5]);
    end
    exp_ptr = 3'd3;
    n_checks++;
    if (dut.r_rr_ptr !== exp_ptr) begin
      n_fail++;
      $display("FAIL single_ptr: rr_ptr=%0d required %0d", dut.r_rr_ptr, exp_ptr);
    end
  endtask

  task automatic test_round_robin();
    int        c0;
    port_idx_t exp_ptr;
    do_reset();
    load(0, tail_m | 32'h0000_0A00);
    load(1, tail_m | 32'h0000_0A01);
    load(4, tail_m | 32'h0000_0A04);
    expect_flit(tail_m | 32'h0000_0A00, 0);
    expect_flit(tail_m | 32'h0000_0A01, 1);
    expect_flit(tail_m | 32'h0000_0A04, 4);
    drive_inputs();
    c0 = cyc;
    wait_drain(40, "rr");
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (push_hist[c0+1+2*k] !== 1'b0 || push_hist[c0+2+2*k] !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_gap: pkt=%0d pushes=%b%b required 01",
                 k, push_hist[c0+1+2*k], push_hist[c0+2+2*k]);
      end
    end
    exp_ptr = 3'd0;
    n_checks++;
    if (dut.r_rr_ptr !== exp_ptr) begin
      n_fail++;
      $display("FAIL rr_wrap_ptr: rr_ptr=%0d required %0d", dut.r_rr_ptr, exp_ptr);
    end
  endtask

  task automatic test_backpressure();
    int c0;
    load(3, 32'h0000_0030);
    load(3, 32'h0000_0031);
    load(3, 32'h8000_0032);
    expect_flit(32'h0000_0030, 3);
    expect_flit(32'h0000_0031, 3);
    expect_flit(32'h8000_0032, 3);
    drive_inputs();
    c0 = cyc;
    tick();
    tick();
    out_full = 1'b1;
    repeat (4) begin
      sample();
      n_checks++;
      if (out_push !== 1'b0 || in_pop !== '0 || out_data !== 32'h0000_0031 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold: push=%b pop=%b data=%h busy=%b required 0 0 00000031 1",
                 out_push, in_pop, out_data, busy);
      end
    end
    tick();
    out_full = 1'b0;
    wait_drain(30, "full");
    n_checks++;
    if (push_hist[c0+7] !== 1'b1 || push_hist[c0+8] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_resume: pushes=%b%b required 11", push_hist[c0+7], push_hist[c0+8]);
    end
  endtask

  task automatic test_stall_hold();
    port_idx_t exp_ptr;
    load(1, 32'h0000_0010);
    load(1, 32'h0000_0011);
    load(2, 32'h8000_0020);
    expect_flit(32'h0000_0010, 1);
    expect_flit(32'h0000_0011, 1);
    expect_flit(32'h8000_0012, 1);
    expect_flit(32'h8000_0020, 2);
    drive_inputs();
    repeat (4) tick();
    repeat (5) begin
      sample();
      n_checks++;
      if (busy !== 1'b1 || owner !== 3'd1 || out_push !== 1'b0 || in_pop !== '0) begin
        n_fail++;
        $display("FAIL stall_lock: busy=%b owner=%0d push=%b pop=%b required 1 1 0 0",
                 busy, owner, out_push, in_pop);
      end
    end
    tick();
    load(1, 32'h8000_0012);
    drive_inputs();
    wait_drain(30, "stall");
    exp_ptr = 3'd3;
    n_checks++;
    if (dut.r_rr_ptr !== exp_ptr) begin
      n_fail++;
      $display("FAIL stall_ptr: rr_ptr=%0d required %0d", dut.r_rr_ptr, exp_ptr);
    end
  endtask

  task automatic test_back_to_back();
    int          c0;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 3; r++) begin
        d = 32'((i << 8) | (r << 4));
        load(i, d);
        load(i, tail_m | d | 32'h1);
      end
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) begin
        d = 32'((i << 8) | (r << 4));
        expect_flit(d, i);
        expect_flit(tail_m | d | 32'h1, i);
      end
    drive_inputs();
    c0 = cyc;
    wait_drain(100, "b2b");
    for (int k = 0; k < 15; k++) begin
      n_checks++;
      if (push_hist[c0+1+3*k] !== 1'b0 || push_hist[c0+2+3*k] !== 1'b1 ||
          push_hist[c0+3+3*k] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_contiguous: pkt=%0d pushes=%b%b%b required 011", k,
                 push_hist[c0+1+3*k], push_hist[c0+2+3*k], push_hist[c0+3+3*k]);
      end
    end
  endtask

  initial begin
    tail_m   = 32'(1) << TAIL_BIT;
    reset    = 1'b1;
    out_full = 1'b0;
    drive_inputs();
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_stall_hold();
    test_back_to_back();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
